// File: rtl/cnn_result_buf.sv
// Result FIFO behind the cnn core: captures {data1_i, data2_i} on valid_i, drained one pair per rd_req rising edge.
// Define RESULT_BUF_CKSUM_EN to add cksum_o, a running 16-bit sum of every accepted pair.
module cnn_result_buf #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_i,
  input  logic [DW-1:0] data1_i,
  input  logic [DW-1:0] data2_i,
  input  logic          clr,
  input  logic          rd_req,
  output logic [DW-1:0] rd_data1_o,
  output logic [DW-1:0] rd_data2_o,
  output logic          rd_valid_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o,
`ifdef RESULT_BUF_CKSUM_EN
  output logic [15:0]   cksum_o,
`endif
  output logic          overflow_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [2*DW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [DW-1:0] rd_data1_q, rd_data1_d;
  logic [DW-1:0] rd_data2_q, rd_data2_d;
  logic          rd_valid_q, rd_valid_d;
  logic          overflow_q, overflow_d;
  logic          rd_req_q, rd_req_d;
`ifdef RESULT_BUF_CKSUM_EN
  logic [15:0]   cksum_q, cksum_d;
`endif

  logic full, empty, pop_req, do_pop, do_push, mem_we;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data1_d = rd_data1_q;
    rd_data2_d = rd_data2_q;
    rd_valid_d = 1'b0;
    overflow_d = overflow_q;
    rd_req_d   = rd_req;
`ifdef RESULT_BUF_CKSUM_EN
    cksum_d    = cksum_q;
`endif

    pop_req = rd_req & ~rd_req_q;
    do_pop  = pop_req & ~empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    do_push = valid_i & (~full | do_pop);
    mem_we  = do_push & ~clr;

    if (clr) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      rd_data1_d = '0;
      rd_data2_d = '0;
      overflow_d = 1'b0;
`ifdef RESULT_BUF_CKSUM_EN
      cksum_d    = '0;
`endif
    end else begin
      if (do_pop) begin
        {rd_data1_d, rd_data2_d} = mem[rd_ptr_q];
        rd_ptr_d   = rd_ptr_q + 1'b1;
        rd_valid_d = 1'b1;
      end
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
`ifdef RESULT_BUF_CKSUM_EN
        cksum_d  = cksum_q + 16'({data1_i, data2_i});
`endif
      end
      if (valid_i & ~do_push) overflow_d = 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; pointers and count make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= {data1_i, data2_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data1_q <= '0;
      rd_data2_q <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      rd_req_q   <= 1'b0;
`ifdef RESULT_BUF_CKSUM_EN
      cksum_q    <= '0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data1_q <= rd_data1_d;
      rd_data2_q <= rd_data2_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
      rd_req_q   <= rd_req_d;
`ifdef RESULT_BUF_CKSUM_EN
      cksum_q    <= cksum_d;
`endif
    end
  end

  assign rd_data1_o = rd_data1_q;
  assign rd_data2_o = rd_data2_q;
  assign rd_valid_o = rd_valid_q;
  assign count_o    = count_q;
  assign full_o     = full;
  assign empty_o    = empty;
  assign overflow_o = overflow_q;
`ifdef RESULT_BUF_CKSUM_EN
  assign cksum_o    = cksum_q;
`endif

endmodule

// File: tb/tb_cnn_result_buf.sv
// Self-checking bench for cnn_result_buf: directed scenarios plus randomized traffic against a queue model.
module tb_cnn_result_buf;

  localparam int DW = 8, DEPTH = 16, AW = 4;

  logic          clk = 1'b0;
  logic          rst_n, valid_i, clr, rd_req;
  logic [DW-1:0] data1_i, data2_i, rd_data1_o, rd_data2_o;
  logic          rd_valid_o, full_o, empty_o, overflow_o;
  logic [AW:0]   count_o;
`ifdef RESULT_BUF_CKSUM_EN
  logic [15:0]   cksum_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the FIFO as a queue of 16-bit pairs.
  logic [15:0] m_q[$];
  logic        m_prev, m_ovf, m_rvalid;
  logic [7:0]  m_rd1, m_rd2;
  logic [15:0] m_ck;

  always #5 clk = ~clk;

  cnn_result_buf #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_i),
    .data1_i    (data1_i),
    .data2_i    (data2_i),
    .clr        (clr),
    .rd_req     (rd_req),
    .rd_data1_o (rd_data1_o),
    .rd_data2_o (rd_data2_o),
    .rd_valid_o (rd_valid_o),
    .count_o    (count_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
`ifdef RESULT_BUF_CKSUM_EN
    .cksum_o    (cksum_o),
`endif
    .overflow_o (overflow_o)
  );

  wire [24:0] dut_vec = {count_o, full_o, empty_o, overflow_o, rd_valid_o, rd_data1_o, rd_data2_o};

  function automatic logic [24:0] exp_vec();
    int n;
    n = m_q.size();
    return {5'(n), n == DEPTH, n == 0, m_ovf, m_rvalid, m_rd1, m_rd2};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_prev = 1'b0; m_ovf = 1'b0; m_rvalid = 1'b0;
    m_rd1 = '0; m_rd2 = '0; m_ck = '0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, return #1 after the edge.
  task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic r);
    logic [15:0] p;
    @(negedge clk);
    valid_i = v; data1_i = a; data2_i = b; clr = c; rd_req = r;
    @(posedge clk);
    m_rvalid = 1'b0;
    if (c) begin
      m_q.delete(); m_ovf = 1'b0; m_rd1 = '0; m_rd2 = '0; m_ck = '0;
    end else begin
      if (r && !m_prev && m_q.size() > 0) begin
        p = m_q.pop_front();
        m_rd1 = p[15:8]; m_rd2 = p[7:0]; m_rvalid = 1'b1;
      end
      if (v) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back({a, b});
          m_ck = m_ck + {a, b};
        end else m_ovf = 1'b1;
      end
    end
    m_prev = r;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_i = 0; data1_i = 0; data2_i = 0; clr = 0; rd_req = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (dut_vec !== 25'b00000_0_1_0_0_00000000_00000000) begin
      n_errors++;
      $display("FAIL reset_state: got %h expected %h", dut_vec, 25'b00000_0_1_0_0_00000000_00000000);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] e1[3] = '{8'h11, 8'h33, 8'h55};
    logic [7:0] e2[3] = '{8'h22, 8'h44, 8'h66};
    int pulses = 0;
    for (int i = 0; i < 3; i++) cycle(1'b1, e1[i], e2[i], 1'b0, 1'b0);
    n_checks++;
    if (count_o !== 5'd3) begin
      n_errors++; $display("FAIL basic_count3: got %0d expected 3", count_o);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      if (rd_valid_o === 1'b1) pulses++;
      n_checks++;
      if ({rd_data1_o, rd_data2_o} !== {e1[i], e2[i]}) begin
        n_errors++;
        $display("FAIL basic_pop%0d: got %h expected %h", i, {rd_data1_o, rd_data2_o}, {e1[i], e2[i]});
      end
      cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      if (rd_valid_o === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 3 || count_o !== 5'd0 || empty_o !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_drain: pulses %0d count %0d empty %b expected 3 0 1", pulses, count_o, empty_o);
    end
  endtask

  task automatic test_hold();
    int pulses = 0;
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 8'($urandom), 8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      if (rd_valid_o === 1'b1) pulses++;
    end
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (pulses != 1 || count_o !== 5'd1) begin
      n_errors++;
      $display("FAIL hold_single_pop: pulses %0d count %0d expected 1 1", pulses, count_o);
    end
  endtask

  task automatic test_overflow();
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 8'(8'hA0 + i), 1'b0, 1'b0);
    n_checks++;
    if (full_o !== 1'b1 || overflow_o !== 1'b0 || count_o !== 5'd16) begin
      n_errors++;
      $display("FAIL ovf_full16: full %b ovf %b count %0d expected 1 0 16", full_o, overflow_o, count_o);
    end
    cycle(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
    n_checks++;
    if (overflow_o !== 1'b1 || count_o !== 5'd16) begin
      n_errors++;
      $display("FAIL ovf_drop17: ovf %b count %0d expected 1 16", overflow_o, count_o);
    end
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      n_checks++;
      if (rd_valid_o !== 1'b1 || {rd_data1_o, rd_data2_o} !== {8'(i), 8'(8'hA0 + i)}) begin
        n_errors++;
        $display("FAIL ovf_drain%0d: valid %b data %h expected 1 %h", i, rd_valid_o,
                 {rd_data1_o, rd_data2_o}, {8'(i), 8'(8'hA0 + i)});
      end
      cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    end
    n_checks++;
    if (overflow_o !== 1'b1 || empty_o !== 1'b1) begin
      n_errors++; $display("FAIL ovf_sticky: ovf %b empty %b expected 1 1", overflow_o, empty_o);
    end
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (overflow_o !== 1'b0 || count_o !== 5'd0 || rd_data1_o !== 8'h00) begin
      n_errors++;
      $display("FAIL ovf_clr: ovf %b count %0d rd1 %h expected 0 0 00", overflow_o, count_o, rd_data1_o);
    end
  endtask

  task automatic test_full_simul();
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h40 + i), 8'(8'hC0 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 8'hDD, 1'b0, 1'b1);
    n_checks++;
    if (count_o !== 5'd16 || overflow_o !== 1'b0 || rd_valid_o !== 1'b1 ||
        {rd_data1_o, rd_data2_o} !== 16'h40C0) begin
      n_errors++;
      $display("FAIL full_simul: count %0d ovf %b valid %b data %h expected 16 0 1 40c0",
               count_o, overflow_o, rd_valid_o, {rd_data1_o, rd_data2_o});
    end
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    end
    n_checks++;
    if ({rd_data1_o, rd_data2_o} !== 16'hEEDD || empty_o !== 1'b1) begin
      n_errors++;
      $display("FAIL full_simul_last: data %h empty %b expected eedd 1", {rd_data1_o, rd_data2_o}, empty_o);
    end
  endtask

  task automatic test_empty_simul();
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h5A, 8'hA5, 1'b0, 1'b1);
    n_checks++;
    if (count_o !== 5'd1 || rd_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL empty_simul: count %0d valid %b expected 1 0", count_o, rd_valid_o);
    end
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (rd_valid_o !== 1'b1 || {rd_data1_o, rd_data2_o} !== 16'h5AA5 || count_o !== 5'd0) begin
      n_errors++;
      $display("FAIL empty_simul_pop: valid %b data %h count %0d expected 1 5aa5 0",
               rd_valid_o, {rd_data1_o, rd_data2_o}, count_o);
    end
  endtask

  task automatic test_random();
    int errs = 0;
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 6, 8'($urandom), 8'($urandom),
            $urandom_range(0, 59) == 0, 1'($urandom));
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_errors++; errs++;
        if (errs < 10) $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
`ifdef RESULT_BUF_CKSUM_EN
      n_checks++;
      if (cksum_o !== m_ck) begin
        n_errors++; errs++;
        if (errs < 10) $display("FAIL random_cksum%0d: got %h expected %h", i, cksum_o, m_ck);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + i), 8'(8'h90 + i), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rd_req = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (dut_vec !== 25'b00000_0_1_0_0_00000000_00000000) begin
      n_errors++;
      $display("FAIL reset_async: got %h expected %h", dut_vec, 25'b00000_0_1_0_0_00000000_00000000);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_errors++; $display("FAIL reset_held: got %h expected %h", dut_vec, exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1; rd_req = 1'b0;
`ifdef RESULT_BUF_CKSUM_EN
    cycle(1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
    cycle(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
    n_checks++;
    if (cksum_o !== 16'h0101) begin
      n_errors++; $display("FAIL cksum_wrap: got %h expected 0101", cksum_o);
    end
`else
    cycle(1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_errors++; $display("FAIL reset_recover: got %h expected %h", dut_vec, exp_vec());
    end
`endif
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_overflow();
    test_full_simul();
    test_empty_simul();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
